// File: rtl/mux_rr_source.sv
// Round-robin source for the 2:1 mux: two valid/ready channels are each
// buffered in a small FIFO and granted alternately into one output register.
module mux_rr_source_fifo #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 2,
    parameter int CW     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [CW-1:0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     rptr, wptr;
    logic              push;

    // Ready looks at occupancy only, so a full FIFO never passes through.
    assign in_ready = (count != FULL);
    assign push     = in_valid && in_ready;
    assign head     = mem[rptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= in_data;
    end
endmodule

module mux_rr_source #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_W-1:0]          a_in_data,
    input  logic                       a_in_valid,
    output logic                       a_in_ready,
    input  logic [DATA_W-1:0]          b_in_data,
    input  logic                       b_in_valid,
    output logic                       b_in_ready,
    output logic [DATA_W-1:0]          a,
    output logic [DATA_W-1:0]          b,
    output logic                       sel,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     a_count,
    output logic [$clog2(DEPTH):0]     b_count
);
    localparam int NUM_LANES = 2;
    localparam int CW        = $clog2(DEPTH) + 1;

    // Lane 0 is channel A, lane 1 is channel B.
    logic [NUM_LANES-1:0][DATA_W-1:0] in_data, head;
    logic [NUM_LANES-1:0][CW-1:0]     count;
    logic [NUM_LANES-1:0]             in_valid, in_ready, pop, nonempty;
    logic                             slot_free, grant_a, grant_b, last_a;

    assign in_data  = {b_in_data, a_in_data};
    assign in_valid = {b_in_valid, a_in_valid};
    assign a_in_ready = in_ready[0];
    assign b_in_ready = in_ready[1];
    assign a_count    = count[0];
    assign b_count    = count[1];

    genvar i;
    generate
        for (i = 0; i < NUM_LANES; i++) begin : g_lane
            mux_rr_source_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CW(CW)) u_fifo (
                .clk      (clk),
                .reset    (reset),
                .in_data  (in_data[i]),
                .in_valid (in_valid[i]),
                .in_ready (in_ready[i]),
                .pop      (pop[i]),
                .head     (head[i]),
                .count    (count[i])
            );
            assign nonempty[i] = (count[i] != '0);
        end
    endgenerate

    // On a tie the channel that did not win last time gets the slot.
    assign slot_free = !out_valid || out_ready;
    assign grant_a   = slot_free && nonempty[0] && (!nonempty[1] || !last_a);
    assign grant_b   = slot_free && nonempty[1] && !grant_a;
    assign pop       = {grant_b, grant_a};

    always_ff @(posedge clk) begin
        if (reset) begin
            a         <= '0;
            b         <= '0;
            sel       <= 1'b0;
            out_valid <= 1'b0;
            last_a    <= 1'b0;
        end else begin
            if (grant_a) begin
                a      <= head[0];
                sel    <= 1'b1;
                last_a <= 1'b1;
            end else if (grant_b) begin
                b      <= head[1];
                sel    <= 1'b0;
                last_a <= 1'b0;
            end
            if (grant_a || grant_b)
                out_valid <= 1'b1;
            else if (out_valid && out_ready)
                out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mux_rr_source.sv
// Randomized scoreboard bench for mux_rr_source against a queue-based model.
module tb_mux_rr_source;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] a_in_data, b_in_data;
    logic              a_in_valid, b_in_valid, a_in_ready, b_in_ready;
    logic [DATA_W-1:0] a, b;
    logic              sel, out_valid, out_ready;
    logic [$clog2(DEPTH):0] a_count, b_count;
    logic [DATA_W-1:0] mux_y;

    mux_rr_source #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .a_in_data(a_in_data), .a_in_valid(a_in_valid), .a_in_ready(a_in_ready),
        .b_in_data(b_in_data), .b_in_valid(b_in_valid), .b_in_ready(b_in_ready),
        .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
        .a_count(a_count), .b_count(b_count)
    );

    always #5 clk = ~clk;
    assign mux_y = sel ? a : b;

    typedef struct { logic s; logic [DATA_W-1:0] d; } exp_t;

    // Reference model: channel queues plus the visible output register.
    logic [DATA_W-1:0] qa[$], qb[$];
    exp_t              expq[$];
    logic [DATA_W-1:0] ma, mb;
    logic              msel, mov, mlast_a;
    bit                chk_en = 0;
    int                ntests = 0, nfail = 0;

    task automatic chk(string nm, int act, int want);
        ntests++;
        if (act != want) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
        end
    endtask

    task automatic model_step();
        bit a_rdy, b_rdy, free, ga, gb;
        exp_t e;
        if (reset) begin
            qa.delete(); qb.delete(); expq.delete();
            ma = '0; mb = '0; msel = 0; mov = 0; mlast_a = 0;
            return;
        end
        a_rdy = qa.size() < DEPTH;
        b_rdy = qb.size() < DEPTH;
        free  = !mov || out_ready;
        ga = free && qa.size() > 0 && (qb.size() == 0 || !mlast_a);
        gb = free && qb.size() > 0 && !ga;
        if (ga) begin
            ma = qa.pop_front(); msel = 1; mlast_a = 1;
            e.s = 1; e.d = ma; expq.push_back(e);
        end else if (gb) begin
            mb = qb.pop_front(); msel = 0; mlast_a = 0;
            e.s = 0; e.d = mb; expq.push_back(e);
        end
        if (ga || gb) mov = 1;
        else if (mov && out_ready) mov = 0;
        if (a_in_valid && a_rdy) qa.push_back(a_in_data);
        if (b_in_valid && b_rdy) qb.push_back(b_in_data);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        chk_en = 1;
        #1;
    endtask

    task automatic drive(bit av, logic [DATA_W-1:0] ad, bit bv, logic [DATA_W-1:0] bd, bit ordy);
        a_in_valid = av; a_in_data = ad;
        b_in_valid = bv; b_in_data = bd;
        out_ready  = ordy;
        tick();
    endtask

    // Monitor: state checks every cycle, scoreboard pop on each consumed word.
    always @(negedge clk) begin
        if (chk_en) begin
            exp_t e;
            chk("out_valid", int'(out_valid), int'(mov));
            chk("a_reg", int'(a), int'(ma));
            chk("b_reg", int'(b), int'(mb));
            chk("sel", int'(sel), int'(msel));
            chk("a_count", int'(a_count), qa.size());
            chk("b_count", int'(b_count), qb.size());
            chk("a_in_ready", int'(a_in_ready), int'(qa.size() < DEPTH));
            chk("b_in_ready", int'(b_in_ready), int'(qb.size() < DEPTH));
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    chk("sb_unexpected_word", 1, 0);
                end else begin
                    e = expq.pop_front();
                    chk("sb_sel", int'(sel), int'(e.s));
                    chk("sb_mux", int'(mux_y), int'(e.d));
                end
            end
        end
    end

    initial begin
        reset = 1; a_in_valid = 0; b_in_valid = 0; a_in_data = 0; b_in_data = 0; out_ready = 0;
        // Reset with both inputs valid: nothing may be accepted.
        drive(1, 4'h3, 1, 4'h4, 1);
        drive(1, 4'h3, 1, 4'h4, 1);
        reset = 0;
        drive(0, 0, 0, 0, 0);
        chk("ready_after_reset", int'(a_in_ready && b_in_ready), 1);

        // Single channel A, E.
        drive(1, 4'hA, 0, 0, 1);
        drive(1, 4'hE, 0, 0, 1);
        repeat (3) drive(0, 0, 0, 0, 1);

        // Round-robin tie: expect 1,7,2,3.
        drive(1, 4'h1, 1, 4'h7, 0);
        drive(1, 4'h2, 1, 4'h3, 0);
        repeat (2) drive(0, 0, 0, 0, 0);
        repeat (6) drive(0, 0, 0, 0, 1);

        // Backpressure: F, 5, C accepted; 9 dropped.
        drive(1, 4'hF, 0, 0, 0);
        drive(1, 4'h5, 0, 0, 0);
        drive(1, 4'hC, 0, 0, 0);
        chk("full_a_count", int'(a_count), 2);
        drive(1, 4'h9, 0, 0, 0);
        repeat (5) drive(0, 0, 0, 0, 1);

        // Streaming A with simultaneous push and pop.
        drive(1, 4'h1, 0, 0, 1);
        drive(1, 4'h2, 0, 0, 1);
        drive(1, 4'h6, 0, 0, 1);
        drive(1, 4'h8, 0, 0, 1);
        repeat (4) drive(0, 0, 0, 0, 1);

        // Mid-stream reset with both FIFOs loaded.
        repeat (4) drive(1, 4'hB, 1, 4'hD, 0);
        reset = 1;
        drive(0, 0, 0, 0, 0);
        reset = 0;
        chk("reset_flush_valid", int'(out_valid), 0);
        repeat (4) drive(0, 0, 0, 0, 1);

        // Randomized traffic with random backpressure and rare resets.
        repeat (3000) begin
            reset = ($urandom_range(0, 299) == 0);
            drive($urandom_range(0, 99) < 55, DATA_W'($urandom),
                  $urandom_range(0, 99) < 55, DATA_W'($urandom),
                  $urandom_range(0, 99) < 70);
        end
        reset = 0;
        repeat (12) drive(0, 0, 0, 0, 1);
        chk("drain_scoreboard_empty", expq.size(), 0);
        chk("drain_out_valid", int'(out_valid), 0);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/mux_rr_source.md
# mux_rr_source

Upstream feeder for the 4-bit 2:1 `mux`. It accepts two independent valid/ready input channels (A and B) and buffers each one in a small FIFO. A round-robin arbiter then drives the mux's `a`, `b` and `sel` inputs from a single output register, qualified by `out_valid`/`out_ready`. The mux output therefore always equals the word most recently granted. Convention: `sel=1` passes `a`, `sel=0` passes `b`.

## Interface
- `DATA_W`, 4, width of each data word; must match the mux width.
- `DEPTH`, 2, entries per channel FIFO; a power of two from 2 to 8.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `a_in_data`  in  DATA_W  channel A write data.
- `a_in_valid`  in  1  channel A write request.
- `a_in_ready`  out  1  channel A FIFO not full.
- `b_in_data`, `b_in_valid`, `b_in_ready`: same roles for channel B.
- `a`  out  DATA_W  registered; drives mux `a`.
- `b`  out  DATA_W  registered; drives mux `b`.
- `sel`  out  1  registered; drives mux `sel` (1 = channel A word, 0 = channel B word).
- `out_valid`  out  1  output register holds an unconsumed word.
- `out_ready`  in  1  downstream consumes the word when `out_valid` and `out_ready` are both high.
- `a_count`, `b_count`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- **Push.** A channel writes its data when `x_in_valid && x_in_ready` at the edge.
  - `x_in_ready = !full`, decoded combinationally from the count.
  - `x_in_ready` does not depend on a same-cycle pop, so there is no pass-through when full.
  - Data presented while ready is low is ignored. Nothing is lost or overwritten.
- **FIFO storage.** Each channel has a circular buffer with read/write pointers.
  - Pointers wrap modulo DEPTH.
  - Occupancy counts saturate at neither end, because push requires not-full and pop requires not-empty.
- **Load condition.** `slot_free = !out_valid || out_ready`. A load happens on an edge where `slot_free` is true and at least one FIFO is non-empty.
- **Grant rules** on a load:
  - Only A non-empty: grant A.
  - Only B non-empty: grant B.
  - Both non-empty: grant the channel opposite to `last_grant`.
- **Effect of a grant.**
  - Grant A: pop A, `a <= head_A`, `sel <= 1`, `b` holds its value, `last_grant <= A`.
  - Grant B: pop B, `b <= head_B`, `sel <= 0`, `a` holds its value, `last_grant <= B`.
- **Output valid.**
  - Goes to 1 on any load.
  - Goes to 0 when the word is consumed (`out_valid && out_ready`) and both FIFOs are empty.
  - Otherwise holds.
- **Simultaneous events.**
  - Push and pop on the same FIFO in one edge: count unchanged, both pointers advance.
  - Consume and load in one edge: back-to-back words with no bubble.
- **Stall.** While `out_valid && !out_ready`, the values of `a`, `b` and `sel` are frozen.
- **Reset** (synchronous, wins over every other event in that cycle):
  - `a=0`, `b=0`, `sel=0`, `out_valid=0`.
  - FIFO pointers and counts cleared, so `a_count=0`, `b_count=0`, and `a_in_ready=b_in_ready=1` after the reset edge.
  - `last_grant = B`, so A wins the first tie.
  - Reset asserted mid-stream discards all buffered and pending words.

## Timing
- **Latency.** A word pushed at edge t into an empty system with a free slot has `out_valid=1` and the word on `a` or `b` after edge t+1. That is one cycle of latency from acceptance to output.
- **Throughput.** One word per cycle while `out_ready` is held high and any FIFO is non-empty.
- **Ready update.** `x_in_ready` falls in the cycle after the edge that fills the FIFO. It rises in the cycle after the edge that pops a full FIFO.
- **Held values.** `a` and `b` retain their last loaded values indefinitely, so the mux output is stable while not valid.
- **Combinational paths.** None from inputs to `a`, `b`, `sel` or `out_valid`; all are registered. Only `x_in_ready` is combinational, and it depends on state only.

## Test plan
- **Reset values.** Assert `reset` for 2 cycles with both inputs valid.
  - All outputs are 0, no push occurs, and the counts stay 0.
  - After release, `a_in_ready=b_in_ready=1`.
- **Single channel.** Push A = `4'hA`, then `4'hE`, with `out_ready=1`.
  - `out_valid` rises 1 cycle after the first push, with `sel=1`, `a=A`, then `a=E`.
  - `b` stays 0 throughout, and the mux output follows A, E.
- **Round-robin tie.** Preload A with {1,2} and B with {7,3} while `out_ready=0`, then raise `out_ready`.
  - `sel` sequence is 1,0,1,0.
  - Mux output sequence is 1,7,2,3.
  - `out_valid` falls after the last word is consumed.
- **Backpressure and full.** Hold `out_ready=0` and push A three times (F, 5, C) with DEPTH=2.
  - F is loaded into the output register.
  - 5 and C fill the FIFO, `a_count=2`, and `a_in_ready=0`.
  - A fourth push of 9 is ignored.
  - Releasing `out_ready` yields F, 5, C, with no 9.
- **Simultaneous push/pop.** With `a_count=1` and `out_ready=1`, push A in the same cycle as a load from A.
  - `a_count` stays 1, and words leave in push order.
- **Mid-stream reset.** With both FIFOs holding 2 words and `out_valid=1`, pulse `reset` for 1 cycle.
  - On the next cycle: `out_valid=0`, counts are 0, and no stale word ever appears afterwards.
